// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a single full-subtractor cell, a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   // state  | meaning
   // IDLE   | waiting for start; operands latched on an accepted start
   // RUN    | one bit of the difference produced per clock, LSB first
   // DONE   | one-cycle result-valid pulse; start ignored
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic bit_diff;
   logic bit_bor;

   assign bit_diff = a_q[0] ^ b_q[0] ^ br_q;
   assign bit_bor  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d = {bit_diff, res_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = bit_bor;
            cnt_d = cnt_q + CW'(1);
            // The last bit lands in the result register and the outputs together.
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               diff_d  = {bit_diff, res_q[WIDTH-1:1]};
               bout_d  = bit_bor;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit and 4-bit instances checked each cycle
// against a timeline model of the handshake plus plain-arithmetic results.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8 = 1'b0, start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       rst4 = 1'b0, start4 = 1'b0, bin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Timeline model: acc = cycle index of the accepting edge; result is a-b-bin in WIDTH+1 bits.
   int         cyc  = 0;
   int         acc8 = -1000;
   int         acc4 = -1000;
   logic [8:0] pend8 = '0, eres8 = '0;
   logic [4:0] pend4 = '0, eres4 = '0;

   always @(posedge clk) begin
      cyc++;
      if (!rst8) begin
         acc8  = -1000;
         eres8 = '0;
      end else begin
         if (cyc - acc8 == 8) eres8 = pend8;
         if (start8 && (cyc - acc8 >= 10)) begin
            acc8  = cyc;
            pend8 = {1'b0, a8} - {1'b0, b8} - {8'b0, bin8};
         end
      end
      if (!rst4) begin
         acc4  = -1000;
         eres4 = '0;
      end else begin
         if (cyc - acc4 == 4) eres4 = pend4;
         if (start4 && (cyc - acc4 >= 6)) begin
            acc4  = cyc;
            pend4 = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
         end
      end
   end

   always @(negedge clk) begin : cmp
      int d8, d4;
      d8 = cyc - acc8;
      d4 = cyc - acc4;
      if (!rst8) begin
         chk("rst_busy8", 32'(busy8), 0);
         chk("rst_done8", 32'(done8), 0);
         chk("rst_diff8", 32'(diff8), 0);
         chk("rst_bout8", 32'(bout8), 0);
      end else begin
         chk("busy8", 32'(busy8), 32'(d8 >= 0 && d8 < 8));
         chk("done8", 32'(done8), 32'(d8 == 8));
         chk("diff8", 32'(diff8), 32'(eres8[7:0]));
         chk("bout8", 32'(bout8), 32'(eres8[8]));
      end
      if (!rst4) begin
         chk("rst_busy4", 32'(busy4), 0);
         chk("rst_done4", 32'(done4), 0);
         chk("rst_diff4", 32'(diff4), 0);
         chk("rst_bout4", 32'(bout4), 0);
      end else begin
         chk("busy4", 32'(busy4), 32'(d4 >= 0 && d4 < 4));
         chk("done4", 32'(done4), 32'(d4 == 4));
         chk("diff4", 32'(diff4), 32'(eres4[3:0]));
         chk("bout4", 32'(bout4), 32'(eres4[4]));
      end
      chk("excl8", 32'(busy8 & done8), 0);
      chk("excl4", 32'(busy4 & done4), 0);
   end

   // One-cycle start pulse, then literal checks of latency, busy length and result.
   task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                         input logic [7:0] ed, input logic eb, input string tag);
      int   n, bc;
      logic dn;
      @(negedge clk);
      if (w == 8) begin a8 = av; b8 = bv; bin8 = bv_in; start8 = 1'b1; end
      else begin a4 = av[3:0]; b4 = bv[3:0]; bin4 = bv_in; start4 = 1'b1; end
      @(negedge clk);
      if (w == 8) start8 = 1'b0; else start4 = 1'b0;
      n  = 0;
      bc = (w == 8) ? int'(busy8) : int'(busy4);
      dn = (w == 8) ? done8 : done4;
      while (!dn && n < 40) begin
         @(negedge clk);
         n++;
         bc += (w == 8) ? int'(busy8) : int'(busy4);
         dn = (w == 8) ? done8 : done4;
      end
      chk({tag, "_latency"}, 32'(n), 32'(w));
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(w));
      chk({tag, "_diff"}, (w == 8) ? 32'(diff8) : 32'(diff4), 32'(ed));
      chk({tag, "_bout"}, (w == 8) ? 32'(bout8) : 32'(bout4), 32'(eb));
   endtask

   task automatic wait_done8(input string tag);
      int n;
      n = 0;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done8), 1);
   endtask

   int perm[512];

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_busy8", 32'(busy8), 0);
      chk("reset_done8", 32'(done8), 0);
      chk("reset_diff8", 32'(diff8), 0);
      chk("reset_bout8", 32'(bout8), 0);
      rst8 = 1'b1;
      rst4 = 1'b1;

      run_op(8, 8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, "sub_100_37");
      run_op(8, 8'd37, 8'd100, 1'b0, 8'hC1, 1'b1, "sub_37_100");
      run_op(8, 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, "sub_0_0_bin");
      run_op(8, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "sub_ff_ff");

      // Start protocol: second start raised mid-RUN and held through DONE.
      @(negedge clk);
      @(negedge clk);
      a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      a8 = 8'd50; b8 = 8'd1; start8 = 1'b1;
      wait_done8("proto_first");
      chk("proto_first_diff", 32'(diff8), 7);
      chk("proto_first_bout", 32'(bout8), 0);
      @(negedge clk);
      chk("proto_done_ignores_start", 32'(busy8), 0);
      @(negedge clk);
      chk("proto_held_start_accepted", 32'(busy8), 1);
      wait_done8("proto_second");
      chk("proto_second_diff", 32'(diff8), 49);
      chk("proto_second_bout", 32'(bout8), 0);
      start8 = 1'b0;

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      @(negedge clk);
      a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst8 = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy8), 0);
      chk("midrst_done", 32'(done8), 0);
      chk("midrst_diff", 32'(diff8), 0);
      chk("midrst_bout", 32'(bout8), 0);
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      run_op(8, 8'd9, 8'd9, 1'b0, 8'd0, 1'b0, "after_rst");

      run_op(4, 8'd5, 8'd3, 1'b1, 8'd1, 1'b0, "w4_5_3_1");
      run_op(4, 8'd3, 8'd5, 1'b0, 8'hE, 1'b1, "w4_3_5_0");

      // Random traffic on the 8-bit instance, including stray starts and rare resets.
      repeat (400) begin
         @(negedge clk);
         #1;
         start8 = ($urandom_range(0, 3) == 0);
         a8     = 8'($urandom);
         b8     = 8'($urandom);
         bin8   = 1'($urandom_range(0, 1));
         rst8   = ($urandom_range(0, 99) != 0);
      end
      @(negedge clk);
      #1;
      start8 = 1'b0;
      rst8   = 1'b1;

      // Exhaustive 4-bit sweep in shuffled order.
      for (int i = 0; i < 512; i++) perm[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(0, i));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         logic [4:0] e;
         v = 9'(perm[i]);
         e = {1'b0, v[3:0]} - {1'b0, v[7:4]} - {4'b0, v[8]};
         run_op(4, {4'b0, v[3:0]}, {4'b0, v[7:4]}, v[8], {4'b0, e[3:0]}, e[4], "sweep4");
      end

      repeat (12) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse of the team's combinational full-adder datapath. It computes a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. A start/busy/done handshake lets a controller or bench launch an operation and collect the difference and borrow-out. It serves as a low-area arithmetic unit and as a sequential cross-check against the adder blocks.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2 or more.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  launch request, sampled only in IDLE
a  input  WIDTH  minuend, sampled with an accepted start
b  input  WIDTH  subtrahend, sampled with an accepted start
bin  input  1  borrow-in, sampled with an accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result is valid
diff  output  WIDTH  a - b - bin modulo 2^WIDTH
bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- One clock domain: clk.
- Reset is asynchronous and active-low on rst_n.
- rst_n low immediately forces:
  - state=IDLE
  - busy=0, done=0, diff=0, bout=0
  - internal shift registers, borrow and bit counter cleared
- Reset has effect mid-operation; any in-flight result is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, latch a, b and bin (the internal borrow takes bin), clear the counter, go to RUN.
  - If start=0, stay in IDLE.
- RUN, on each edge:
  - Bit cell: d = a0 ^ b0 ^ br. Next borrow = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the MSB of the result register (the result shifts right).
  - Shift the operand registers right by 1 and increment the counter.
  - After the edge that processes bit WIDTH-1, go to DONE.
- DONE:
  - Lasts exactly one cycle; then go to IDLE unconditionally.
  - start is ignored in DONE.
- Outputs are registered and decoded from state:
  - busy=1 only in RUN.
  - done=1 only in DONE.
- diff and bout update on the edge entering DONE. They hold until the next entry to DONE or a reset.
- diff and bout are not disturbed during a subsequent RUN.
- Latency:
  - Let E0 be the edge on which start is accepted.
  - busy is high after E0 through E(WIDTH).
  - done is high for the cycle after edge E(WIDTH).
  - The next start can be accepted at E(WIDTH+2) at the earliest.
- start=1 in RUN or DONE is ignored, with no queuing. Operands changing during RUN have no effect.
- start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the borrow out of the MSB.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, one-cycle start pulse -> busy high for 8 cycles; done pulse at cycle 9 after the start edge; diff=8'h3F (63), bout=0.
- WIDTH=8, a=37, b=100, bin=0 -> diff=8'hC1 (193), bout=1. Separately, a=0, b=0, bin=1 -> diff=8'hFF, bout=1. a=8'hFF, b=8'hFF, bin=0 -> diff=8'h00, bout=0.
- Start protocol: pulse start with a=10, b=3. Two cycles later raise start with a=50, b=1 and hold it through DONE. Required: the first result is diff=7, bout=0, with no corruption from the second operands. The held start is accepted only in the following IDLE cycle, and that operation yields diff=49.
- Reset mid-operation: start a=200, b=55, then drop rst_n at RUN cycle 4 without waiting for a clock edge. Required: busy, done, diff and bout go to 0 at once, and no done pulse is issued. After release, a new start with a=9, b=9 gives diff=0, bout=0.
- WIDTH=4 instance: a=5, b=3, bin=1 -> diff=4'd1, bout=0, done after 4 RUN cycles. Then a=3, b=5, bin=0 -> diff=4'hE, bout=1.
- Randomized-but-directed sweep, WIDTH=4: all 512 combinations of a, b and bin, each compared against {bout,diff} = a - b - bin computed in 5 bits -> zero mismatches. Also check that busy and done are never high in the same cycle.
